// File: rtl/debounce_pkg.sv
// Project-wide defaults shared by the input-conditioning blocks.
package debounce_pkg;

  localparam int unsigned SAMPLE_NUM_DEFAULT  = 16;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Counter width able to hold values 0..n.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_sync_ff.sv
// Flop-chain synchroniser bringing an asynchronous level into the clk domain.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: output changes only after the synchronised input has disagreed
// with it for SAMPLE_NUM consecutive edges.
module debounce
  import debounce_pkg::*;
#(
  parameter int unsigned SAMPLE_NUM  = SAMPLE_NUM_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic i_Sample_Rate,
  input  logic i_Reset,
  input  logic i_Signal,
  output logic o_Signal
);

  localparam int unsigned    CW   = count_width(SAMPLE_NUM);
  localparam logic [CW-1:0]  LAST = CW'(SAMPLE_NUM - 1);

  logic          s_Sync;
  logic [CW-1:0] count;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (i_Sample_Rate),
    .rst (i_Reset),
    .d   (i_Signal),
    .q   (s_Sync)
  );

  // Any sample agreeing with the output restarts qualification.
  always_ff @(posedge i_Sample_Rate) begin
    if (i_Reset) begin
      count    <= '0;
      o_Signal <= 1'b0;
    end else if (s_Sync == o_Signal) begin
      count    <= '0;
    end else if (count == LAST) begin
      o_Signal <= s_Sync;
      count    <= '0;
    end else begin
      count    <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: directed table, latency sequences, randomized model compare.
module tb_debounce;

  localparam int unsigned N = 10;

  logic clk = 1'b0;
  logic i_Reset = 1'b1;
  logic i_Signal = 1'b0;
  logic o10;
  logic o1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  debounce #(.SAMPLE_NUM(N), .SYNC_STAGES(2)) dut10 (
    .i_Sample_Rate (clk),
    .i_Reset       (i_Reset),
    .i_Signal      (i_Signal),
    .o_Signal      (o10)
  );

  debounce #(.SAMPLE_NUM(1), .SYNC_STAGES(2)) dut1 (
    .i_Sample_Rate (clk),
    .i_Reset       (i_Reset),
    .i_Signal      (i_Signal),
    .o_Signal      (o1)
  );

  // Reference: output flips once the last N synchronised samples all differ from it.
  logic sync_q[$] = '{1'b0, 1'b0};
  logic hist[$];
  logic raw1_q[$] = '{1'b0, 1'b0, 1'b0};
  logic m_o  = 1'b0;
  logic m_o1 = 1'b0;

  always @(posedge clk) begin
    logic s;
    logic all_diff;
    if (i_Reset) begin
      sync_q = '{1'b0, 1'b0};
      raw1_q = '{1'b0, 1'b0, 1'b0};
      hist.delete();
      m_o  = 1'b0;
      m_o1 = 1'b0;
    end else begin
      s = sync_q.pop_front();
      sync_q.push_back(i_Signal);
      hist.push_back(s);
      if (hist.size() > N) void'(hist.pop_front());
      all_diff = (hist.size() == N);
      foreach (hist[j]) if (hist[j] == m_o) all_diff = 1'b0;
      if (all_diff) begin
        m_o = s;
        hist.delete();
      end
      void'(raw1_q.pop_front());
      raw1_q.push_back(i_Signal);
      m_o1 = raw1_q[0];
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic sig, input logic rst);
    @(negedge clk);
    i_Signal = sig;
    i_Reset  = rst;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sig;
    logic        rst;
    int unsigned cycles;
    logic        exp_mid;
    logic        exp_last;
  } seg_t;

  seg_t tbl[$];

  initial begin
    int lat;
    logic val;
    int unsigned len;

    tbl.push_back('{1'b1, 1'b1,  3, 1'b0, 1'b0}); // reset with input high
    tbl.push_back('{1'b1, 1'b0, 12, 1'b0, 1'b1}); // clean rise on 12th edge
    tbl.push_back('{1'b0, 1'b0, 12, 1'b1, 1'b0}); // clean fall on 12th edge
    tbl.push_back('{1'b1, 1'b0,  5, 1'b0, 1'b0}); // short pulse
    tbl.push_back('{1'b0, 1'b0, 14, 1'b0, 1'b0}); // rejected
    tbl.push_back('{1'b1, 1'b0,  5, 1'b0, 1'b0}); // high 5
    tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0}); // 1-cycle dip
    tbl.push_back('{1'b1, 1'b0, 12, 1'b0, 1'b1}); // rises 12 after final rise
    tbl.push_back('{1'b0, 1'b0,  1, 1'b1, 1'b1}); // low glitch while high
    tbl.push_back('{1'b1, 1'b0, 14, 1'b1, 1'b1}); // stays high
    tbl.push_back('{1'b0, 1'b0, 12, 1'b1, 1'b0}); // held low falls on 12th
    tbl.push_back('{1'b1, 1'b0,  9, 1'b0, 1'b0}); // count reaches 7
    tbl.push_back('{1'b1, 1'b1,  1, 1'b0, 1'b0}); // reset pulse mid-count
    tbl.push_back('{1'b1, 1'b0, 12, 1'b0, 1'b1}); // re-qualifies from zero
    tbl.push_back('{1'b0, 1'b0, 12, 1'b1, 1'b0}); // back to low

    for (int i = 0; i < tbl.size(); i++) begin
      for (int unsigned c = 1; c <= tbl[i].cycles; c++) begin
        step(tbl[i].sig, tbl[i].rst);
        check($sformatf("row%0d_cyc%0d", i, c), o10,
              (c == tbl[i].cycles) ? tbl[i].exp_last : tbl[i].exp_mid);
        if (tbl[i].rst) check_int($sformatf("row%0d_count_in_reset", i), int'(dut10.count), 0);
      end
      if (i == 11) check_int("count_before_reset", int'(dut10.count), 7);
    end

    // Measured latency, rising then falling, with a bounded wait.
    for (int dir = 0; dir < 2; dir++) begin
      lat = -1;
      for (int e = 1; e <= 40; e++) begin
        step((dir == 0) ? 1'b1 : 1'b0, 1'b0);
        if (o10 == ((dir == 0) ? 1'b1 : 1'b0)) begin
          lat = e;
          break;
        end
      end
      check_int((dir == 0) ? "rise_latency" : "fall_latency", lat, 12);
    end

    // Randomized bursty input, occasional reset, against the reference.
    for (int b = 0; b < 120; b++) begin
      len = $urandom_range(1, 24);
      val = 1'($urandom_range(0, 1));
      for (int unsigned c = 0; c < len; c++) begin
        step(val, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        check("rand_n10", o10, m_o);
        check("rand_n1", o1, m_o1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
